// File: rtl/triangle_dispatch.sv
// triangle_dispatch: walks the projected-triangle RAM once per frame, culls
// degenerate and fully off-screen triangles, and hands each survivor to
// triangle_color as a single-cycle valid pulse, waiting for its last_out.
module triangle_dispatch #(
    parameter int TRIANGLES   = 72,
    parameter int RAM_LATENCY = 2,
    parameter int WIDTH       = 1024,
    parameter int HEIGHT      = 720
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             start_in,
    input  logic [$clog2(TRIANGLES+1)-1:0]   tri_count_in,
    output logic [$clog2(TRIANGLES)-1:0]     rd_addr_out,
    input  logic [83:0]                      rd_data_in,
    output logic                             tc_valid_out,
    output logic [19:0]                      vertex_a_out,
    output logic [19:0]                      vertex_b_out,
    output logic [19:0]                      vertex_c_out,
    output logic [23:0]                      color_out,
    input  logic                             tc_last_in,
    output logic                             busy_out,
    output logic                             frame_done_out,
    output logic [$clog2(TRIANGLES+1)-1:0]   drawn_count_out,
    output logic [$clog2(TRIANGLES+1)-1:0]   culled_count_out
);

    localparam int AW = $clog2(TRIANGLES);
    localparam int CW = $clog2(TRIANGLES + 1);
    localparam int WW = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
    localparam logic [CW-1:0] MAX_COUNT = CW'(TRIANGLES);
    localparam logic [WW-1:0] WAIT_LAST = WW'(RAM_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        CHECK  = 3'd2,
        ISSUE  = 3'd3,
        RASTER = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   count_q, count_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic            first_q, first_d;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    logic            tc_valid_q, tc_valid_d;
    logic [19:0]     vertex_a_q, vertex_a_d;
    logic [19:0]     vertex_b_q, vertex_b_d;
    logic [19:0]     vertex_c_q, vertex_c_d;
    logic [23:0]     color_q, color_d;
    logic            busy_q, busy_d;
    logic            frame_done_q, frame_done_d;
    logic [CW-1:0]   drawn_q, drawn_d;
    logic [CW-1:0]   culled_q, culled_d;

    logic [9:0]          ax, ay, bx, by, cx, cy;
    logic signed [10:0]  dxb, dyb, dxc, dyc;
    logic signed [21:0]  prod_b, prod_c;
    logic signed [22:0]  area2;
    logic [9:0]          min_x, min_y;
    logic                degenerate, off_screen;
    logic [CW-1:0]       count_clamped;
    logic                advance;

    // Cull tests evaluated straight off the RAM data word seen during CHECK
    always_comb begin
        ax = rd_data_in[83:74];
        ay = rd_data_in[73:64];
        bx = rd_data_in[63:54];
        by = rd_data_in[53:44];
        cx = rd_data_in[43:34];
        cy = rd_data_in[33:24];
        dxb = $signed({1'b0, bx}) - $signed({1'b0, ax});
        dyb = $signed({1'b0, by}) - $signed({1'b0, ay});
        dxc = $signed({1'b0, cx}) - $signed({1'b0, ax});
        dyc = $signed({1'b0, cy}) - $signed({1'b0, ay});
        prod_b = 22'(dxb) * 22'(dyc);
        prod_c = 22'(dyb) * 22'(dxc);
        area2 = 23'(prod_b) - 23'(prod_c);
        degenerate = (area2 == '0);
        min_x = (ax < bx) ? ax : bx;
        min_x = (cx < min_x) ? cx : min_x;
        min_y = (ay < by) ? ay : by;
        min_y = (cy < min_y) ? cy : min_y;
        off_screen = (int'(min_x) >= WIDTH) || (int'(min_y) >= HEIGHT);
    end

    // Next-state and next-output computation; every output is registered
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        count_d      = count_q;
        wait_d       = wait_q;
        first_d      = first_q;
        rd_addr_d    = rd_addr_q;
        vertex_a_d   = vertex_a_q;
        vertex_b_d   = vertex_b_q;
        vertex_c_d   = vertex_c_q;
        color_d      = color_q;
        drawn_d      = drawn_q;
        culled_d     = culled_q;
        advance      = 1'b0;
        count_clamped = (tri_count_in > MAX_COUNT) ? MAX_COUNT : tri_count_in;

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    count_d  = count_clamped;
                    idx_d    = '0;
                    drawn_d  = '0;
                    culled_d = '0;
                    wait_d   = '0;
                    state_d  = (count_clamped == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (wait_q == WAIT_LAST) begin
                    wait_d  = '0;
                    state_d = CHECK;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            CHECK: begin
                if (degenerate || off_screen) begin
                    if (culled_q < MAX_COUNT) culled_d = culled_q + 1'b1;
                    advance = 1'b1;
                end else begin
                    vertex_a_d = rd_data_in[83:64];
                    vertex_b_d = rd_data_in[63:44];
                    vertex_c_d = rd_data_in[43:24];
                    color_d    = rd_data_in[23:0];
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (drawn_q < MAX_COUNT) drawn_d = drawn_q + 1'b1;
                first_d = 1'b1;
                state_d = RASTER;
            end
            RASTER: begin
                if (first_q) begin
                    first_d = 1'b0;
                end else if (tc_last_in) begin
                    advance = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (advance) begin
            if (idx_q == AW'(count_q - 1'b1)) begin
                state_d = DONE;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = FETCH;
            end
        end

        if (state_d == FETCH) rd_addr_d = idx_d;
        tc_valid_d   = (state_d == ISSUE);
        frame_done_d = (state_d == DONE);
        busy_d       = (state_d != IDLE);
    end

    // Single state/output register bank with synchronous active-low reset
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            count_q      <= '0;
            wait_q       <= '0;
            first_q      <= 1'b0;
            rd_addr_q    <= '0;
            tc_valid_q   <= 1'b0;
            vertex_a_q   <= '0;
            vertex_b_q   <= '0;
            vertex_c_q   <= '0;
            color_q      <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            drawn_q      <= '0;
            culled_q     <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            count_q      <= count_d;
            wait_q       <= wait_d;
            first_q      <= first_d;
            rd_addr_q    <= rd_addr_d;
            tc_valid_q   <= tc_valid_d;
            vertex_a_q   <= vertex_a_d;
            vertex_b_q   <= vertex_b_d;
            vertex_c_q   <= vertex_c_d;
            color_q      <= color_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            drawn_q      <= drawn_d;
            culled_q     <= culled_d;
        end
    end

    assign rd_addr_out      = rd_addr_q;
    assign tc_valid_out     = tc_valid_q;
    assign vertex_a_out     = vertex_a_q;
    assign vertex_b_out     = vertex_b_q;
    assign vertex_c_out     = vertex_c_q;
    assign color_out        = color_q;
    assign busy_out         = busy_q;
    assign frame_done_out   = frame_done_q;
    assign drawn_count_out  = drawn_q;
    assign culled_count_out = culled_q;

endmodule

// File: tb/tb_triangle_dispatch.sv
// tb_triangle_dispatch: directed scenarios for triangle_dispatch with a
// two-stage RAM model. Cycle 0 is the cycle in which start_in is high; each
// later negedge is the middle of the next cycle.
module tb_triangle_dispatch;

    logic         clk_in;
    logic         rst_in;
    logic         start_in;
    logic [6:0]   tri_count_in;
    logic [6:0]   rd_addr_out;
    logic [83:0]  rd_data_in;
    logic         tc_valid_out;
    logic [19:0]  vertex_a_out, vertex_b_out, vertex_c_out;
    logic [23:0]  color_out;
    logic         tc_last_in;
    logic         busy_out;
    logic         frame_done_out;
    logic [6:0]   drawn_count_out;
    logic [6:0]   culled_count_out;

    logic [83:0]  mem [0:71];
    logic [83:0]  pipe1;

    int n_compared;
    int n_mismatched;

    triangle_dispatch #(
        .TRIANGLES(72), .RAM_LATENCY(2), .WIDTH(1024), .HEIGHT(720)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
        .tri_count_in(tri_count_in), .rd_addr_out(rd_addr_out),
        .rd_data_in(rd_data_in), .tc_valid_out(tc_valid_out),
        .vertex_a_out(vertex_a_out), .vertex_b_out(vertex_b_out),
        .vertex_c_out(vertex_c_out), .color_out(color_out),
        .tc_last_in(tc_last_in), .busy_out(busy_out),
        .frame_done_out(frame_done_out), .drawn_count_out(drawn_count_out),
        .culled_count_out(culled_count_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // RAM model: data for an address appears two cycles after the address
    always @(posedge clk_in) begin
        pipe1      <= mem[rd_addr_out];
        rd_data_in <= pipe1;
    end

    function automatic logic [83:0] rec(int ax, int ay, int bx, int by,
                                        int cx, int cy, logic [23:0] col);
        return {10'(ax), 10'(ay), 10'(bx), 10'(by), 10'(cx), 10'(cy), col};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 72; i++) mem[i] = '0;
    endtask

    task automatic start_frame(input int count);
        @(negedge clk_in);
        start_in     = 1'b1;
        tri_count_in = 7'(count);
    endtask

    task automatic test_reset();
        rst_in   = 1'b0;
        start_in = 1'b1;
        tri_count_in = 7'd1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_in);
            n_compared++;
            if ({rd_addr_out, vertex_a_out, vertex_b_out, vertex_c_out, color_out, tc_valid_out,
                 busy_out, frame_done_out, drawn_count_out, culled_count_out} !== '0) begin
                n_mismatched++;
                $display("[TB] FAIL reset_outputs: busy=%b valid=%b done=%b addr=%0d",
                         busy_out, tc_valid_out, frame_done_out, rd_addr_out);
            end
        end
        start_in = 1'b0;
        rst_in   = 1'b1;
    endtask

    task automatic test_single_triangle();
        logic [83:0] r;
        r = rec(10, 10, 20, 10, 10, 20, 24'h0000FF);
        clear_mem();
        mem[0] = r;
        start_frame(1);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk_in);
            start_in = 1'b0;
            if (c == 1) begin
                n_compared++;
                if (rd_addr_out !== 7'd0 || busy_out !== 1'b1) begin
                    n_mismatched++;
                    $display("[TB] FAIL single_fetch: addr=%0d busy=%b expected addr 0 busy 1", rd_addr_out, busy_out);
                end
            end
            n_compared++;
            if (tc_valid_out !== (c == 4)) begin
                n_mismatched++;
                $display("[TB] FAIL single_valid c=%0d: got %b expected %b", c, tc_valid_out, (c == 4));
            end
            if (c == 4 || c == 11) begin
                n_compared++;
                if ({vertex_a_out, vertex_b_out, vertex_c_out, color_out} !== r) begin
                    n_mismatched++;
                    $display("[TB] FAIL single_record c=%0d: got %h expected %h", c,
                             {vertex_a_out, vertex_b_out, vertex_c_out, color_out}, r);
                end
            end
            n_compared++;
            if (frame_done_out !== (c == 10)) begin
                n_mismatched++;
                $display("[TB] FAIL single_done c=%0d: got %b expected %b", c, frame_done_out, (c == 10));
            end
            if (c == 11) begin
                n_compared++;
                if (busy_out !== 1'b0 || drawn_count_out !== 7'd1 || culled_count_out !== 7'd0) begin
                    n_mismatched++;
                    $display("[TB] FAIL single_counts: busy=%b drawn=%0d culled=%0d expected 0/1/0",
                             busy_out, drawn_count_out, culled_count_out);
                end
            end
            tc_last_in = (c == 9);
        end
        tc_last_in = 1'b0;
    endtask

    task automatic test_degenerate();
        clear_mem();
        mem[0] = rec(0, 0, 5, 5, 10, 10, 24'h123456);
        start_frame(1);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_in);
            start_in = 1'b0;
            n_compared++;
            if (tc_valid_out !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL degen_valid c=%0d: got %b expected 0", c, tc_valid_out);
            end
            n_compared++;
            if (frame_done_out !== (c == 4)) begin
                n_mismatched++;
                $display("[TB] FAIL degen_done c=%0d: got %b expected %b", c, frame_done_out, (c == 4));
            end
        end
        n_compared++;
        if (culled_count_out !== 7'd1 || drawn_count_out !== 7'd0 || busy_out !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL degen_counts: culled=%0d drawn=%0d busy=%b expected 1/0/0",
                     culled_count_out, drawn_count_out, busy_out);
        end
    endtask

    task automatic test_mixed_frame();
        logic [83:0] exp_rec [0:1];
        int issues;
        int last_at;
        clear_mem();
        mem[0] = rec(100, 100, 300, 120, 150, 400, 24'h112233);
        mem[1] = rec(100, 720, 200, 730, 150, 800, 24'h445566);
        mem[2] = rec(500, 50, 520, 300, 900, 200, 24'hABCDEF);
        exp_rec[0] = mem[0];
        exp_rec[1] = mem[2];
        issues  = 0;
        last_at = -1;
        start_frame(3);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk_in);
            start_in = 1'b0;
            n_compared++;
            if (tc_valid_out !== (c == 4 || c == 14)) begin
                n_mismatched++;
                $display("[TB] FAIL mixed_valid c=%0d: got %b expected %b", c, tc_valid_out, (c == 4 || c == 14));
            end
            if (tc_valid_out === 1'b1) begin
                if (issues < 2) begin
                    n_compared++;
                    if ({vertex_a_out, vertex_b_out, vertex_c_out, color_out} !== exp_rec[issues]) begin
                        n_mismatched++;
                        $display("[TB] FAIL mixed_record%0d: got %h expected %h", issues,
                                 {vertex_a_out, vertex_b_out, vertex_c_out, color_out}, exp_rec[issues]);
                    end
                end
                issues++;
                last_at = c + 3;
            end
            n_compared++;
            if (frame_done_out !== (c == 18)) begin
                n_mismatched++;
                $display("[TB] FAIL mixed_done c=%0d: got %b expected %b", c, frame_done_out, (c == 18));
            end
            tc_last_in = (c == last_at);
        end
        tc_last_in = 1'b0;
        n_compared++;
        if (issues != 2 || drawn_count_out !== 7'd2 || culled_count_out !== 7'd1) begin
            n_mismatched++;
            $display("[TB] FAIL mixed_counts: issues=%0d drawn=%0d culled=%0d expected 2/2/1",
                     issues, drawn_count_out, culled_count_out);
        end
    endtask

    task automatic test_count_zero();
        start_frame(0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk_in);
            start_in = 1'b0;
            n_compared++;
            if (frame_done_out !== (c == 1) || busy_out !== (c == 1) || tc_valid_out !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL zero_frame c=%0d: done=%b busy=%b valid=%b expected done=%b busy=%b valid=0",
                         c, frame_done_out, busy_out, tc_valid_out, (c == 1), (c == 1));
            end
        end
        n_compared++;
        if (drawn_count_out !== 7'd0 || culled_count_out !== 7'd0) begin
            n_mismatched++;
            $display("[TB] FAIL zero_counts: drawn=%0d culled=%0d expected 0/0", drawn_count_out, culled_count_out);
        end
    endtask

    task automatic test_clamp();
        clear_mem();
        start_frame(100);
        for (int c = 1; c <= 220; c++) begin
            @(negedge clk_in);
            start_in = 1'b0;
            n_compared++;
            if (frame_done_out !== (c == 217) || tc_valid_out !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL clamp_done c=%0d: done=%b valid=%b expected done=%b valid=0",
                         c, frame_done_out, tc_valid_out, (c == 217));
            end
            if (c == 214) begin
                n_compared++;
                if (rd_addr_out !== 7'd71) begin
                    n_mismatched++;
                    $display("[TB] FAIL clamp_last_addr: got %0d expected 71", rd_addr_out);
                end
            end
        end
        n_compared++;
        if (culled_count_out !== 7'd72 || drawn_count_out !== 7'd0) begin
            n_mismatched++;
            $display("[TB] FAIL clamp_counts: culled=%0d drawn=%0d expected 72/0", culled_count_out, drawn_count_out);
        end
    endtask

    task automatic test_stale_last();
        clear_mem();
        mem[0] = rec(10, 10, 20, 10, 10, 20, 24'h0000FF);
        tc_last_in = 1'b1;
        start_frame(1);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk_in);
            start_in = 1'b0;
            if (c == 1) begin
                n_compared++;
                if (busy_out !== 1'b1) begin
                    n_mismatched++;
                    $display("[TB] FAIL stale_start_wins: busy=%b expected 1", busy_out);
                end
            end
            n_compared++;
            if (frame_done_out !== (c == 10)) begin
                n_mismatched++;
                $display("[TB] FAIL stale_done c=%0d: got %b expected %b", c, frame_done_out, (c == 10));
            end
            tc_last_in = (c <= 5) || (c == 9);
        end
        tc_last_in = 1'b0;
    endtask

    task automatic test_start_ignored();
        clear_mem();
        mem[0] = rec(10, 10, 20, 10, 10, 20, 24'h00FF00);
        start_frame(1);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk_in);
            start_in = (c == 6);
            if (c == 6) tri_count_in = 7'd3;
            n_compared++;
            if (tc_valid_out !== (c == 4) || frame_done_out !== (c == 10) || rd_addr_out !== 7'd0) begin
                n_mismatched++;
                $display("[TB] FAIL ignore_start c=%0d: valid=%b done=%b addr=%0d expected valid=%b done=%b addr=0",
                         c, tc_valid_out, frame_done_out, rd_addr_out, (c == 4), (c == 10));
            end
            tc_last_in = (c == 9);
        end
        tc_last_in = 1'b0;
        n_compared++;
        if (drawn_count_out !== 7'd1) begin
            n_mismatched++;
            $display("[TB] FAIL ignore_start_drawn: got %0d expected 1", drawn_count_out);
        end
    endtask

    task automatic test_reset_mid_raster();
        logic [83:0] r;
        r = rec(10, 10, 20, 10, 10, 20, 24'hFF0000);
        clear_mem();
        mem[0] = r;
        start_frame(1);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk_in);
            start_in = 1'b0;
            if (c >= 7) begin
                n_compared++;
                if ({rd_addr_out, vertex_a_out, vertex_b_out, vertex_c_out, color_out, tc_valid_out,
                     busy_out, frame_done_out, drawn_count_out, culled_count_out} !== '0) begin
                    n_mismatched++;
                    $display("[TB] FAIL abort_outputs c=%0d: busy=%b done=%b valid=%b drawn=%0d",
                             c, busy_out, frame_done_out, tc_valid_out, drawn_count_out);
                end
            end
            rst_in     = (c != 6);
            tc_last_in = (c == 8);
        end
        tc_last_in = 1'b0;
        start_frame(1);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk_in);
            start_in = 1'b0;
            if (c == 1) begin
                n_compared++;
                if (rd_addr_out !== 7'd0 || busy_out !== 1'b1) begin
                    n_mismatched++;
                    $display("[TB] FAIL restart_fetch: addr=%0d busy=%b expected 0/1", rd_addr_out, busy_out);
                end
            end
            n_compared++;
            if (tc_valid_out !== (c == 4) || frame_done_out !== (c == 7)) begin
                n_mismatched++;
                $display("[TB] FAIL restart_frame c=%0d: valid=%b done=%b expected valid=%b done=%b",
                         c, tc_valid_out, frame_done_out, (c == 4), (c == 7));
            end
            if (c == 4) begin
                n_compared++;
                if ({vertex_a_out, vertex_b_out, vertex_c_out, color_out} !== r) begin
                    n_mismatched++;
                    $display("[TB] FAIL restart_record: got %h expected %h",
                             {vertex_a_out, vertex_b_out, vertex_c_out, color_out}, r);
                end
            end
            tc_last_in = (c == 6);
        end
        tc_last_in = 1'b0;
        n_compared++;
        if (drawn_count_out !== 7'd1 || culled_count_out !== 7'd0) begin
            n_mismatched++;
            $display("[TB] FAIL restart_counts: drawn=%0d culled=%0d expected 1/0", drawn_count_out, culled_count_out);
        end
    endtask

    // Scenario sequence followed by the summary line
    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst_in       = 1'b0;
        start_in     = 1'b0;
        tri_count_in = '0;
        tc_last_in   = 1'b0;
        clear_mem();
        test_reset();
        test_single_triangle();
        test_degenerate();
        test_mixed_frame();
        test_count_zero();
        test_clamp();
        test_stale_last();
        test_start_ignored();
        test_reset_mid_raster();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
